// File: rtl/dma_param_priority_arbiter_if.sv
// rtl/dma_param_priority_arbiter_if.sv - request/grant bundle between the RRAs, DMATranCtrl and the arbiter
interface dma_param_priority_arbiter_if #(
    parameter int NO_OF_REQS       = 4,
    parameter int NUM_OF_BDS_WIDTH = 2,
    parameter int REQ_IDX_WIDTH    = 2
);
    logic [NO_OF_REQS-1:0]                  req;
    logic                                   arbMode;
    logic                                   nextReq;
    logic                                   clrReq;
    logic [NO_OF_REQS*NUM_OF_BDS_WIDTH-1:0] intDscrptrNumIn;
    logic [NO_OF_REQS-1:0]                  strDscrptrIn;

    logic [NO_OF_REQS-1:0]                  reqEn;
    logic                                   rdEn_intext;
    logic                                   tranDataAvail;
    logic                                   strDscrptr;
    logic [NUM_OF_BDS_WIDTH-1:0]            intDscrptrNum;
    logic [NO_OF_REQS-1:0]                  priLvl;
    logic [REQ_IDX_WIDTH-1:0]               grantIdx;
    logic                                   starveGrant;

    modport master (
        output req, arbMode, nextReq, clrReq, intDscrptrNumIn, strDscrptrIn,
        input  reqEn, rdEn_intext, tranDataAvail, strDscrptr, intDscrptrNum,
               priLvl, grantIdx, starveGrant
    );

    modport slave (
        input  req, arbMode, nextReq, clrReq, intDscrptrNumIn, strDscrptrIn,
        output reqEn, rdEn_intext, tranDataAvail, strDscrptr, intDscrptrNum,
               priLvl, grantIdx, starveGrant
    );
endinterface

// File: rtl/dma_param_priority_arbiter.sv
// rtl/dma_param_priority_arbiter.sv - fixed-priority / round-robin DMA requester arbiter
// Optional starvation age guard enabled by defining ARB_STARVE_GUARD_EN.
module dma_param_priority_arbiter #(
    parameter int NO_OF_REQS       = 4,
    parameter int NUM_OF_BDS_WIDTH = 2,
    parameter int REQ_IDX_WIDTH    = 2,
    parameter int AGE_WIDTH        = 4,
    parameter int AGE_LIMIT        = 8
) (
    input logic                        clock,
    input logic                        resetn,
    dma_param_priority_arbiter_if.slave bus
);
    localparam int N  = NO_OF_REQS;
    localparam int W  = NUM_OF_BDS_WIDTH;
    localparam int IW = REQ_IDX_WIDTH;

    if (N < 1 || N > 16 || (1 << IW) < N ||
        AGE_LIMIT < 1 || AGE_LIMIT >= (1 << AGE_WIDTH)) begin : g_bad_cfg
        $error("dma_param_priority_arbiter: illegal parameter set");
    end

    typedef enum logic {ACTIVE = 1'b0, WAIT = 1'b1} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            grant_en;
    logic [N-1:0]    grant_d;
    logic [N-1:0]    starved;
    logic [IW-1:0]   win_idx;
    logic            win_starved;
    logic [W-1:0]    win_num;
    logic            win_str;
    logic [IW-1:0]   rr_ptr;

    logic [N-1:0]    pri_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    num_q;
    logic            str_q;
    logic            avail_q;
    logic            starve_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ACTIVE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACTIVE:  if (|bus.req)     state_nxt = WAIT;
            WAIT:    if (bus.nextReq)  state_nxt = ACTIVE;
            default:                   state_nxt = ACTIVE;
        endcase
    end

    always_comb begin
        grant_en        = (state == ACTIVE) && (|bus.req);
        bus.rdEn_intext = grant_en;
        bus.reqEn       = grant_en ? grant_d : '0;
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [AGE_WIDTH-1:0] age [N];

    always_comb begin
        for (int i = 0; i < N; i++)
            starved[i] = bus.req[i] && (age[i] == AGE_WIDTH'(AGE_LIMIT));
    end

    // Ages only advance on grant edges, but drop as soon as a requester withdraws.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] || (grant_en && grant_d[i]))
                    age[i] <= '0;
                else if (grant_en && age[i] != AGE_WIDTH'(AGE_LIMIT))
                    age[i] <= age[i] + 1'b1;
            end
        end
    end
`else
    assign starved = '0;
`endif

    // Starved requesters pre-empt the mode-based scan; the lowest starved index wins.
    always_comb begin : sel_comb
        logic          found;
        int            jn;
        logic [IW-1:0] j_idx;
        found       = 1'b0;
        jn          = 0;
        j_idx       = '0;
        win_idx     = '0;
        win_starved = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && starved[i]) begin
                win_idx     = IW'(i);
                win_starved = 1'b1;
                found       = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            jn = bus.arbMode ? int'(rr_ptr) + i : i;
            if (jn >= N) jn = jn - N;
            j_idx = IW'(jn);
            if (!found && bus.req[j_idx]) begin
                win_idx = j_idx;
                found   = 1'b1;
            end
        end
        grant_d = '0;
        win_num = '0;
        win_str = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (found && win_idx == IW'(i)) begin
                grant_d[i] = 1'b1;
                win_num    = bus.intDscrptrNumIn[i*W +: W];
                win_str    = bus.strDscrptrIn[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pri_q    <= '0;
            idx_q    <= '0;
            num_q    <= '0;
            str_q    <= 1'b0;
            avail_q  <= 1'b0;
            starve_q <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            if (grant_en) begin
                pri_q    <= grant_d;
                idx_q    <= win_idx;
                num_q    <= win_num;
                str_q    <= win_str;
                starve_q <= win_starved;
                rr_ptr   <= (win_idx == IW'(N-1)) ? '0 : win_idx + 1'b1;
            end
            if (grant_en)        avail_q <= 1'b1;
            else if (bus.clrReq) avail_q <= 1'b0;
        end
    end

    assign bus.priLvl        = pri_q;
    assign bus.grantIdx      = idx_q;
    assign bus.intDscrptrNum = num_q;
    assign bus.strDscrptr    = str_q;
    assign bus.tranDataAvail = avail_q;
    assign bus.starveGrant   = starve_q;
endmodule
